ram_burst_master: RTL and testbench

- Initiator that drives the single-port synchronous RAM's native interface (we, re, addr, din, dout).
- Converts valid/ready burst requests from a client into per-beat RAM write or read cycles.
- Returns read data on a valid/ready response channel.
- Sits between processing blocks and the RAM instance and is the only driver of the RAM's control pins.

---
 rtl/ram_burst_master.sv | 135 +++++++++++++
 tb/tb_ram_burst_master.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM: turns valid/ready burst
// requests into per-beat RAM write/read cycles and returns read data on a response channel.
module ram_burst_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]    beats_left_q, beats_left_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    done_q, done_d;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    done_d       = 1'b0;
    req_ready    = 1'b0;
    wdata_ready  = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cur_addr_d   = req_addr;
          beats_left_d = req_len;
          state_d      = req_write ? WR : RD_ISSUE;
        end
      end
      WR: begin
        wdata_ready = 1'b1;
        mem_we      = wdata_valid;
        if (wdata_valid) begin
          if (beats_left_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cur_addr_d   = cur_addr_q + ADDR_WIDTH'(1);
            beats_left_d = beats_left_q - LEN_WIDTH'(1);
          end
        end
      end
      RD_ISSUE: begin
        mem_re  = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // RAM output is valid now, one cycle after it sampled mem_re.
        rsp_rdata_d = mem_dout;
        rsp_valid_d = 1'b1;
        state_d     = RD_RESP;
      end
      RD_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (beats_left_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cur_addr_d   = cur_addr_q + ADDR_WIDTH'(1);
            beats_left_d = beats_left_q - LEN_WIDTH'(1);
            state_d      = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      done_q       <= done_d;
    end
  end

  assign mem_addr  = cur_addr_q;
  assign mem_din   = wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// Directed bench for ram_burst_master with a behavioural single-port RAM
// (write has priority, registered read data) attached to its memory pins.
module tb_ram_burst_master;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          busy, done;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  logic [AW-1:0] wlog_a[$];

  logic [DW-1:0] ram     [16];
  logic [DW-1:0] exp_ram [16];
  logic [DW-1:0] wtab    [16];

  ram_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy), .done(done),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we)      ram[mem_addr] <= mem_din;
    else if (mem_re) mem_dout      <= ram[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we) wlog_a.push_back(mem_addr);
    if (mem_we && mem_re) overlap_cnt <= overlap_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wrap(input int x);
    return x & 15;
  endfunction

  // Ends in the done cycle so a caller may issue the next request back-to-back.
  task automatic do_write(input int a, input int len, input int gap_at, input int gap_n);
    int start;
    start = wlog_a.size();
    check("wr_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = AW'(a); req_len = LW'(len);
    tick();
    req_valid = 1'b0;
    check("wr_busy", busy, 1);
    for (int b = 0; b <= len; b++) begin
      if (b == gap_at) begin
        wdata_valid = 1'b0;
        for (int g = 0; g < gap_n; g++) begin
          #1;
          check("wr_gap_we", mem_we, 0);
          check("wr_gap_wready", wdata_ready, 1);
          tick();
        end
      end
      wdata_valid = 1'b1;
      wdata = wtab[b];
      #1;
      check("wr_we", mem_we, 1);
      check("wr_addr", mem_addr, wrap(a + b));
      check("wr_din", mem_din, wtab[b]);
      exp_ram[wrap(a + b)] = wtab[b];
      tick();
    end
    wdata_valid = 1'b0;
    check("wr_done", done, 1);
    check("wr_idle", busy, 0);
    check("wr_done_ready", req_ready, 1);
    check("wr_beats", wlog_a.size() - start, len + 1);
  endtask

  task automatic do_read(input int a, input int len, input int stall_beat, input int stall_n);
    logic [DW-1:0] e;
    check("rd_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(a); req_len = LW'(len);
    rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      e = exp_ram[wrap(a + b)];
      check("rd_re", mem_re, 1);
      check("rd_excl_we", mem_we, 0);
      check("rd_addr", mem_addr, wrap(a + b));
      check("rd_issue_valid", rsp_valid, 0);
      tick();
      check("rd_wait_valid", rsp_valid, 0);
      check("rd_wait_re", mem_re, 0);
      tick();
      check("rd_valid", rsp_valid, 1);
      check("rd_data", rsp_rdata, e);
      if (b == stall_beat) begin
        rsp_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          check("rd_stall_valid", rsp_valid, 1);
          check("rd_stall_data", rsp_rdata, e);
        end
        rsp_ready = 1'b1;
      end
      tick();
      check("rd_hs_valid", rsp_valid, 0);
    end
    check("rd_done", done, 1);
    check("rd_idle", busy, 0);
    check("rd_done_ready", req_ready, 1);
  endtask

  initial begin
    int start;
    int dc;
    int cnt [16];

    rst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wdata_valid = 1'b0; wdata = '0; rsp_ready = 1'b0;

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_we", mem_we, 0);
    check("rst_re", mem_re, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_req_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single write then single read at address 3
    wtab[0] = 8'hA5;
    do_write(3, 0, -1, 0);
    tick();
    check("t1_done_pulse", done, 0);
    do_read(3, 0, -1, 0);
    tick();
    check("t1_rd_done_pulse", done, 0);

    // Wrapping write with a 2-cycle gap after beat 2
    wtab[0] = 8'h11; wtab[1] = 8'h22; wtab[2] = 8'h33; wtab[3] = 8'h44;
    do_write(14, 3, 2, 2);
    tick();

    // Wrapping read with a 3-cycle stall on the first beat
    do_read(14, 3, 0, 3);
    tick();

    // Max length: 16 beats from address 5, data = address
    for (int b = 0; b < 16; b++) wtab[b] = DW'(wrap(5 + b));
    start = wlog_a.size();
    do_write(5, 15, -1, 0);
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    for (int i = start; i < wlog_a.size(); i++) cnt[wlog_a[i]]++;
    for (int i = 0; i < 16; i++) check("max_cover", cnt[i], 1);
    check("max_last_addr", wlog_a[wlog_a.size() - 1], 4);
    tick();
    do_read(5, 15, -1, 0);
    tick();

    // Reset after 2 beats of a 4-beat write to address 8
    start = wlog_a.size();
    check("mr_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd8; req_len = 4'd3;
    tick();
    req_valid = 1'b0;
    wdata_valid = 1'b1; wdata = 8'hC1; tick();
    wdata = 8'hC2; tick();
    wdata = 8'hC3;
    dc = done_cnt;
    #2;
    rst = 1'b0;
    #1;
    check("mr_busy", busy, 0);
    check("mr_we", mem_we, 0);
    check("mr_re", mem_re, 0);
    check("mr_addr", mem_addr, 0);
    check("mr_done", done, 0);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_rsp_rdata", rsp_rdata, 0);
    tick();
    check("mr_we_hold", mem_we, 0);
    wdata_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    check("mr_no_done", done_cnt, dc);
    check("mr_beats", wlog_a.size() - start, 2);
    exp_ram[8] = 8'hC1;
    exp_ram[9] = 8'hC2;
    do_read(8, 3, -1, 0);

    // Back-to-back: next read accepted in the done cycle
    do_read(0, 1, -1, 0);
    tick();
    check("b2b_done_pulse", done, 0);

    check("done_total", done_cnt, 8);
    check("we_re_overlap", overlap_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
